// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: op codes, flag-register control codes, FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL1 = 4'h8;
    localparam logic [3:0] OP_SHR1 = 4'h9;
    localparam logic [3:0] OP_SAR1 = 4'hA;
    localparam logic [3:0] OP_SHLN = 4'hB;
    localparam logic [3:0] OP_SHRN = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_CLC  = 4'hE;
    localparam logic [3:0] OP_STC  = 4'hF;

    typedef enum logic [1:0] {
        SST_LOAD = 2'b00,
        SST_CLC  = 2'b01,
        SST_STC  = 2'b10,
        SST_HOLD = 2'b11
    } sst_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the ALU sequencer and its controller.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             c;
    logic             z;
    logic             v;
    logic             s;
    logic [1:0]       sst;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, result, result_hi, c, z, v, s, sst
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, result, result_hi, c, z, v, s, sst
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per step; o_product is the
// accumulator value after the current step, so it is the full product when o_done=1.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);
    localparam int unsigned CNTW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNTW-1:0]    r_cnt;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
        w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_mcand <= i_a;
            r_acc   <= {{WIDTH{1'b0}}, i_b};
            r_cnt   <= CNTW'(WIDTH);
        end else if (i_step && (r_cnt != '0)) begin
            r_acc   <= w_acc_nxt;
            r_cnt   <= r_cnt - CNTW'(1);
        end
    end

    assign o_done    = i_step && (r_cnt == CNTW'(1));
    assign o_product = w_acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU feeding the flag register. Define ALU_SEQ_MUL_EN to build the
// iterative multiplier; otherwise op D completes immediately as a flag-neutral pass of a.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int unsigned CW  = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    state_e           r_state, w_state_nxt;
    logic [3:0]       r_op, w_op_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [WIDTH-1:0] r_result_hi, w_result_hi_nxt;
    logic             r_c, w_c_nxt;
    logic             r_z, w_z_nxt;
    logic             r_v, w_v_nxt;
    logic             r_s, w_s_nxt;
    sst_e             r_sst, w_sst_nxt;

    logic [CW-1:0]    w_k;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_c;
    logic             w_sc_v;
    logic             w_sc_clr;
    sst_e             w_sc_sst;
    logic [WIDTH-1:0] w_step;
    logic             w_out;

`ifdef ALU_SEQ_MUL_EN
    logic               w_mul_start;
    logic               w_mul_step;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    assign w_mul_start = (r_state == ST_IDLE) && bus.start && (bus.op == OP_MUL);
    assign w_mul_step  = (r_state == ST_ITER) && (r_op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_step    (w_mul_step),
        .i_a       (bus.a),
        .i_b       (bus.b),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );
`endif

    assign w_k = bus.b[CW-1:0];

    // Single-cycle datapath, evaluated straight from the request so results land on edge 0.
    always_comb begin
        w_sum    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, (bus.op == OP_ADC) & bus.cin};
        w_dif    = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, (bus.op == OP_SBB) & bus.cin};
        w_sc_res = bus.a;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        w_sc_clr = 1'b0;
        w_sc_sst = SST_LOAD;
        unique case (bus.op)
            OP_ADD, OP_ADC: begin
                w_sc_res = w_sum[MSB:0];
                w_sc_c   = w_sum[WIDTH];
                w_sc_v   = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
            end
            OP_SUB, OP_SBB: begin
                w_sc_res = w_dif[MSB:0];
                w_sc_c   = w_dif[WIDTH];
                w_sc_v   = (bus.a[MSB] != bus.b[MSB]) && (w_dif[MSB] != bus.a[MSB]);
            end
            OP_AND:  w_sc_res = bus.a & bus.b;
            OP_OR:   w_sc_res = bus.a | bus.b;
            OP_XOR:  w_sc_res = bus.a ^ bus.b;
            OP_NOT:  w_sc_res = ~bus.a;
            OP_SHL1: begin
                w_sc_res = {bus.a[MSB-1:0], 1'b0};
                w_sc_c   = bus.a[MSB];
            end
            OP_SHR1: begin
                w_sc_res = {1'b0, bus.a[MSB:1]};
                w_sc_c   = bus.a[0];
            end
            OP_SAR1: begin
                w_sc_res = {bus.a[MSB], bus.a[MSB:1]};
                w_sc_c   = bus.a[0];
            end
            OP_SHLN, OP_SHRN: w_sc_sst = SST_HOLD;
            OP_MUL: begin
                w_sc_sst = SST_HOLD;
                w_sc_clr = 1'b1;
            end
            OP_CLC: begin
                w_sc_sst = SST_CLC;
                w_sc_clr = 1'b1;
            end
            OP_STC: begin
                w_sc_sst = SST_STC;
                w_sc_clr = 1'b1;
            end
            default: w_sc_res = bus.a;
        endcase
    end

    always_comb begin
        if (r_op == OP_SHLN) begin
            w_step = {r_sh[MSB-1:0], 1'b0};
            w_out  = r_sh[MSB];
        end else begin
            w_step = {1'b0, r_sh[MSB:1]};
            w_out  = r_sh[0];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_cnt_nxt       = r_cnt;
        w_sh_nxt        = r_sh;
        w_done_nxt      = 1'b0;
        w_result_nxt    = r_result;
        w_result_hi_nxt = r_result_hi;
        w_c_nxt         = r_c;
        w_z_nxt         = r_z;
        w_v_nxt         = r_v;
        w_s_nxt         = r_s;
        w_sst_nxt       = SST_HOLD;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_op_nxt = bus.op;
                    if ((bus.op == OP_SHLN || bus.op == OP_SHRN) && (w_k != '0)) begin
                        w_state_nxt = ST_ITER;
                        w_cnt_nxt   = w_k;
                        w_sh_nxt    = bus.a;
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (bus.op == OP_MUL) begin
                        w_state_nxt = ST_ITER;
                    end
`endif
                    else begin
                        w_done_nxt      = 1'b1;
                        w_result_nxt    = w_sc_res;
                        w_result_hi_nxt = '0;
                        w_c_nxt         = w_sc_c;
                        w_v_nxt         = w_sc_v;
                        w_z_nxt         = !w_sc_clr && (w_sc_res == '0);
                        w_s_nxt         = !w_sc_clr && w_sc_res[MSB];
                        w_sst_nxt       = w_sc_sst;
                    end
                end
            end
            ST_ITER: begin
`ifdef ALU_SEQ_MUL_EN
                if (r_op == OP_MUL) begin
                    if (w_mul_done) begin
                        w_state_nxt     = ST_IDLE;
                        w_done_nxt      = 1'b1;
                        w_result_nxt    = w_prod[MSB:0];
                        w_result_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
                        w_c_nxt         = (w_prod[2*WIDTH-1:WIDTH] != '0);
                        w_v_nxt         = (w_prod[2*WIDTH-1:WIDTH] != '0);
                        w_z_nxt         = (w_prod == '0);
                        w_s_nxt         = w_prod[2*WIDTH-1];
                        w_sst_nxt       = SST_LOAD;
                    end
                end else
`endif
                begin
                    // The last step publishes the shifted word directly instead of storing it first.
                    if (r_cnt == CW'(1)) begin
                        w_state_nxt     = ST_IDLE;
                        w_done_nxt      = 1'b1;
                        w_result_nxt    = w_step;
                        w_result_hi_nxt = '0;
                        w_c_nxt         = w_out;
                        w_v_nxt         = 1'b0;
                        w_z_nxt         = (w_step == '0);
                        w_s_nxt         = w_step[MSB];
                        w_sst_nxt       = SST_LOAD;
                    end else begin
                        w_sh_nxt  = w_step;
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_v         <= 1'b0;
            r_s         <= 1'b0;
            r_sst       <= SST_HOLD;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sh        <= w_sh_nxt;
            r_done      <= w_done_nxt;
            r_result    <= w_result_nxt;
            r_result_hi <= w_result_hi_nxt;
            r_c         <= w_c_nxt;
            r_z         <= w_z_nxt;
            r_v         <= w_v_nxt;
            r_s         <= w_s_nxt;
            r_sst       <= w_sst_nxt;
        end
    end

    assign bus.busy      = (r_state == ST_ITER);
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.c         = r_c;
    assign bus.z         = r_z;
    assign bus.v         = r_v;
    assign bus.s         = r_s;
    assign bus.sst       = r_sst;

endmodule
